// File: rtl/time_pkg.sv
// Shared mode encoding, time-field limits and BCD increment helpers for the
// time-of-day counter.
package time_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HRS  = 2'd1,
    SET_MINS = 2'd2
  } mode_t;

  localparam int MAX_SEC          = 59;
  localparam int MAX_MIN_TENS     = 5;
  localparam int MAX_HR_TENS      = 2;
  localparam int MAX_HR_ONES_AT_2 = 3;

  // Returns {tens, ones} of the next hour, wrapping 23 -> 00.
  function automatic logic [6:0] inc_hours(input logic [2:0] tens, input logic [3:0] ones);
    if (tens == 3'(MAX_HR_TENS) && ones == 4'(MAX_HR_ONES_AT_2))
      return 7'd0;
    else if (ones == 4'd9)
      return {tens + 3'd1, 4'd0};
    else
      return {tens, ones + 4'd1};
  endfunction

  // Returns {tens, ones} of the next minute, wrapping 59 -> 00.
  function automatic logic [6:0] inc_mins(input logic [2:0] tens, input logic [3:0] ones);
    if (ones != 4'd9)
      return {tens, ones + 4'd1};
    else if (tens == 3'(MAX_MIN_TENS))
      return 7'd0;
    else
      return {tens + 3'd1, 4'd0};
  endfunction

endpackage

// File: rtl/time_keeper_bcd_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted press (release is silent).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          press_reg;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      press_reg <= 1'b0;
      if (sync_reg[1] == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        // Change accepted; pulse only when the new level is "pressed".
        stable_reg <= sync_reg[1];
        cnt_reg    <= '0;
        press_reg  <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign stable = stable_reg;
  assign press  = press_reg;

endmodule

// File: rtl/time_keeper_bcd.sv
// 24 h time-of-day counter with BCD hh:mm outputs, 1 Hz prescaler and a
// two-button set mode (mode cycles RUN/SET_HRS/SET_MINS, inc bumps the field).
module time_keeper_bcd
  import time_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [2:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [2:0] mins_tens,
  output logic [3:0] mins_ones,
  output logic [5:0] secs,
  output logic [1:0] set_mode,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_press;
  logic [1:0] btn_stable_unused;

  assign btn_raw = {btn_inc, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .raw       (btn_raw[gi]),
        .stable    (btn_stable_unused[gi]),
        .press     (btn_press[gi])
      );
    end
  endgenerate

  logic mode_press, inc_press;
  assign mode_press = btn_press[0];
  assign inc_press  = btn_press[1];

  mode_t         mode_reg, mode_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [5:0]    secs_reg, secs_next;
  logic [2:0]    hrs_tens_reg, hrs_tens_next, mins_tens_reg, mins_tens_next;
  logic [3:0]    hrs_ones_reg, hrs_ones_next, mins_ones_reg, mins_ones_next;
  logic [6:0]    hrs_inc, mins_inc;
  logic          tick;

  assign hrs_inc  = inc_hours(hrs_tens_reg, hrs_ones_reg);
  assign mins_inc = inc_mins(mins_tens_reg, mins_ones_reg);
  // Prescaler is pinned at 0 outside RUN, so this can only fire while running.
  assign tick     = (presc_reg == PRESC_MAX);

  always_comb begin
    mode_next      = mode_reg;
    presc_next     = presc_reg;
    secs_next      = secs_reg;
    hrs_tens_next  = hrs_tens_reg;
    hrs_ones_next  = hrs_ones_reg;
    mins_tens_next = mins_tens_reg;
    mins_ones_next = mins_ones_reg;
    if (mode_press) begin
      // Mode change wins over a coincident inc press.
      presc_next = '0;
      case (mode_reg)
        RUN: begin
          mode_next = SET_HRS;
          secs_next = '0;
        end
        SET_HRS:  mode_next = SET_MINS;
        SET_MINS: begin
          mode_next = RUN;
          secs_next = '0;
        end
        default:  mode_next = RUN;
      endcase
    end else begin
      case (mode_reg)
        RUN: begin
          if (tick) begin
            presc_next = '0;
            if (secs_reg == 6'(MAX_SEC)) begin
              secs_next = '0;
              {mins_tens_next, mins_ones_next} = mins_inc;
              if (mins_inc == 7'd0)
                {hrs_tens_next, hrs_ones_next} = hrs_inc;
            end else begin
              secs_next = secs_reg + 6'd1;
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        SET_HRS: begin
          presc_next = '0;
          if (inc_press)
            {hrs_tens_next, hrs_ones_next} = hrs_inc;
        end
        SET_MINS: begin
          presc_next = '0;
          if (inc_press)
            {mins_tens_next, mins_ones_next} = mins_inc;
        end
        default: begin
          mode_next  = RUN;
          presc_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      mode_reg      <= RUN;
      presc_reg     <= '0;
      secs_reg      <= '0;
      hrs_tens_reg  <= '0;
      hrs_ones_reg  <= '0;
      mins_tens_reg <= '0;
      mins_ones_reg <= '0;
    end else begin
      mode_reg      <= mode_next;
      presc_reg     <= presc_next;
      secs_reg      <= secs_next;
      hrs_tens_reg  <= hrs_tens_next;
      hrs_ones_reg  <= hrs_ones_next;
      mins_tens_reg <= mins_tens_next;
      mins_ones_reg <= mins_ones_next;
    end
  end

  assign hrs_tens  = hrs_tens_reg;
  assign hrs_ones  = hrs_ones_reg;
  assign mins_tens = mins_tens_reg;
  assign mins_ones = mins_ones_reg;
  assign secs      = secs_reg;
  assign set_mode  = mode_reg;
  assign sec_tick  = tick;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Bench for time_keeper_bcd: seconds-of-day reference model checked every
// cycle, plus table-driven set-mode vectors and hand-written corner sequences.
module tb_time_keeper_bcd;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int LAT    = DEB + 3;  // raw rise to visible effect, in edges

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       btn_mode   = 1'b0;
  logic       btn_inc    = 1'b0;
  logic [2:0] hrs_tens, mins_tens;
  logic [3:0] hrs_ones, mins_ones;
  logic [5:0] secs;
  logic [1:0] set_mode;
  logic       sec_tick;
  logic [22:0] dut_out;

  time_keeper_bcd #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hrs_tens  (hrs_tens),
    .hrs_ones  (hrs_ones),
    .mins_tens (mins_tens),
    .mins_ones (mins_ones),
    .secs      (secs),
    .set_mode  (set_mode),
    .sec_tick  (sec_tick)
  );

  assign dut_out = {hrs_tens, hrs_ones, mins_tens, mins_ones, secs, set_mode, sec_tick};

  always #5 clk_100MHz = ~clk_100MHz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Reference model: time as seconds since midnight, mode 0/1/2, prescaler.
  int m_sod = 0, m_mode = 0, m_presc = 0;
  int mode_ev = -1, inc_ev = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sod = 0; m_mode = 0; m_presc = 0; mode_ev = -1; inc_ev = -1;
  endtask

  task automatic model_step();
    bit mp, ip;
    mp = (mode_ev == cyc);
    ip = (inc_ev == cyc);
    if (mp) begin
      m_presc = 0;
      if (m_mode != 1) m_sod = m_sod - (m_sod % 60);
      m_mode = (m_mode + 1) % 3;
    end else if (m_mode == 0) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        m_sod = (m_sod + 1) % 86400;
      end else begin
        m_presc++;
      end
    end else if (ip) begin
      if (m_mode == 1) begin
        m_sod = (((m_sod / 3600) + 1) % 24) * 3600 + (m_sod % 3600);
      end else begin
        int mm;
        mm = (m_sod / 60) % 60;
        m_sod = m_sod - mm * 60 + ((mm + 1) % 60) * 60;
      end
    end
  endtask

  function automatic logic [22:0] model_out();
    int h, m, s;
    h = m_sod / 3600;
    m = (m_sod / 60) % 60;
    s = m_sod % 60;
    return {3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 6'(s), 2'(m_mode),
            (m_mode == 0 && m_presc == CLK_HZ - 1)};
  endfunction

  always @(posedge clk_100MHz) begin
    cyc = cyc + 1;
    if (!reset) model_step();
  end

  always @(negedge clk_100MHz)
    check("cycle_model", {9'd0, dut_out}, {9'd0, model_out()});

  function automatic int dut_hours();
    return int'(hrs_tens) * 10 + int'(hrs_ones);
  endfunction

  function automatic int dut_mins();
    return int'(mins_tens) * 10 + int'(mins_ones);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    wait_cyc(2);
    reset = 1'b0;
    if (btn_mode) mode_ev = cyc + LAT;
    if (btn_inc)  inc_ev  = cyc + LAT;
  endtask

  task automatic press(input bit do_mode, input bit do_inc, input int hold, input int gap);
    if (do_mode) begin btn_mode = 1'b1; mode_ev = cyc + LAT; end
    if (do_inc)  begin btn_inc  = 1'b1; inc_ev  = cyc + LAT; end
    wait_cyc(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic set_time(input int h, input int m);
    do_reset();
    press(1, 0, 10, 10);
    repeat (h) press(0, 1, 10, 10);
    press(1, 0, 10, 10);
    repeat (m) press(0, 1, 10, 10);
    press(1, 0, 10, 10);
  endtask

  typedef struct {
    int start_h; int start_m; int hr_inc; int min_inc; int exp_h; int exp_m;
  } vec_t;

  vec_t vecs[4];
  int   pre_h[3];
  int   post_h[3];

  initial begin
    int ticks, n, h0, m0;

    vecs[0] = '{0, 0, 25, 61, 1, 1};
    vecs[1] = '{23, 30, 1, 0, 0, 30};
    vecs[2] = '{7, 59, 0, 1, 7, 0};
    vecs[3] = '{0, 0, 24, 60, 0, 0};
    pre_h   = '{9, 19, 23};
    post_h  = '{10, 20, 0};

    model_clear();
    wait_cyc(2);
    check("reset_state", {9'd0, dut_out}, 32'd0);
    reset = 1'b0;

    // 1 hour of free running
    do_reset();
    ticks = 0;
    for (int i = 0; i < CLK_HZ * 3600; i++) begin
      wait_cyc(1);
      if (sec_tick) ticks++;
    end
    check("t1_ticks", ticks, 3600);
    check("t1_hours", dut_hours(), 1);
    check("t1_mins", dut_mins(), 0);
    check("t1_secs", secs, 0);
    $display("t1 run 1h: ticks=%0d time=%0d:%0d:%0d", ticks, dut_hours(), dut_mins(), secs);

    // hour-boundary rollovers
    for (int k = 0; k < 3; k++) begin
      set_time(pre_h[k], 59);
      n = 0;
      while (!(secs == 6'd59 && sec_tick) && n < 800) begin
        wait_cyc(1);
        n++;
      end
      check("t2_reach_59s", n < 800, 1);
      wait_cyc(1);
      check("t2_hours", dut_hours(), post_h[k]);
      check("t2_mins", dut_mins(), 0);
      check("t2_secs", secs, 0);
      $display("t2 rollover from %0d:59:59 -> %0d:%0d:%0d", pre_h[k], dut_hours(), dut_mins(), secs);
    end

    // glitch rejection and single increment on long hold, in SET_HRS
    do_reset();
    press(1, 0, 10, 10);
    btn_inc = 1'b1;
    wait_cyc(3);
    btn_inc = 1'b0;
    wait_cyc(12);
    check("t3_glitch", dut_hours(), 0);
    btn_inc = 1'b1;
    inc_ev  = cyc + LAT;
    wait_cyc(LAT - 1);
    check("t3_before_lat", dut_hours(), 0);
    wait_cyc(1);
    check("t3_at_lat", dut_hours(), 1);
    wait_cyc(20 - LAT);
    btn_inc = 1'b0;
    wait_cyc(12);
    check("t3_no_repeat", dut_hours(), 1);
    $display("t3 glitch/hold: hours=%0d", dut_hours());

    // table-driven set-mode vectors
    for (int v = 0; v < 4; v++) begin
      set_time(vecs[v].start_h, vecs[v].start_m);
      press(1, 0, 10, 10);
      check("t4_mode_set_hrs", set_mode, 1);
      repeat (vecs[v].hr_inc) press(0, 1, 10, 10);
      check("t4_hours", dut_hours(), vecs[v].exp_h);
      check("t4_mins_kept", dut_mins(), vecs[v].start_m);
      press(1, 0, 10, 10);
      check("t4_mode_set_mins", set_mode, 2);
      repeat (vecs[v].min_inc) press(0, 1, 10, 10);
      check("t4_mins", dut_mins(), vecs[v].exp_m);
      check("t4_hours_kept", dut_hours(), vecs[v].exp_h);
      $display("t4 vec %0d: %0d:%0d +%0dh +%0dm -> %0d:%0d", v, vecs[v].start_h, vecs[v].start_m,
               vecs[v].hr_inc, vecs[v].min_inc, dut_hours(), dut_mins());
    end

    // return to RUN: secs cleared, first tick after a full second
    do_reset();
    press(1, 0, 10, 10);
    press(1, 0, 10, 10);
    press(0, 1, 10, 10);
    btn_mode = 1'b1;
    mode_ev  = cyc + LAT;
    wait_cyc(LAT - 1);
    check("t5_still_set", set_mode, 2);
    wait_cyc(1);
    check("t5_run", set_mode, 0);
    check("t5_secs0", secs, 0);
    n = 1;
    while (!sec_tick && n < 30) begin
      wait_cyc(1);
      n++;
    end
    check("t5_first_tick", n, CLK_HZ);
    btn_mode = 1'b0;
    wait_cyc(10);
    h0 = dut_hours();
    m0 = dut_mins();
    press(0, 1, 10, 10);
    check("t5_inc_run_h", dut_hours(), h0);
    check("t5_inc_run_m", dut_mins(), m0);
    $display("t5 return to run: first tick after %0d cycles, time %0d:%0d", n, dut_hours(), dut_mins());

    // simultaneous mode+inc in SET_HRS
    do_reset();
    press(1, 0, 10, 10);
    press(0, 1, 10, 10);
    press(0, 1, 10, 10);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    mode_ev  = cyc + LAT;
    inc_ev   = cyc + LAT;
    wait_cyc(LAT);
    check("t6_both_mode", set_mode, 2);
    check("t6_both_hours", dut_hours(), 2);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_cyc(10);

    // reset mid-debounce in SET_MINS: immediate clear, no spurious press
    btn_mode = 1'b1;
    wait_cyc(3);
    reset = 1'b1;
    model_clear();
    btn_mode = 1'b0;
    #1;
    check("t6_async_reset", {9'd0, dut_out}, 32'd0);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(20);
    check("t6_no_spurious", set_mode, 0);
    $display("t6 reset mid-debounce: mode=%0d time=%0d:%0d", set_mode, dut_hours(), dut_mins());

    // button held through reset release gives one press after a full debounce
    btn_mode = 1'b1;
    do_reset();
    wait_cyc(LAT - 1);
    check("t6_held_before", set_mode, 0);
    wait_cyc(1);
    check("t6_held_press", set_mode, 1);
    btn_mode = 1'b0;
    wait_cyc(10);

    // randomized button traffic against the reference model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0:       wait_cyc($urandom_range(5, 60));
        1:       press(1, 0, $urandom_range(5, 15), $urandom_range(8, 12));
        2:       press(0, 1, $urandom_range(5, 15), $urandom_range(8, 12));
        default: press(1, 1, $urandom_range(5, 15), $urandom_range(8, 12));
      endcase
      $display("rand %0d op=%0d mode=%0d time=%0d:%0d:%0d", it, op, set_mode, dut_hours(), dut_mins(), secs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
